// File: rtl/dds_pkg.sv
// dds_pkg: shared sample width, FIFO defaults, generator type codes and capture FSM states.
package dds_pkg;
  localparam int SAMPLE_W = 12;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_ADDR_W = 4;
  localparam logic [SAMPLE_W-1:0] DEF_IDLE_CODE = '0;
  typedef enum logic [1:0] {
    SIG_NONE  = 2'd0,
    SIG_LFM   = 2'd1,
    SIG_TONE  = 2'd2,
    SIG_NOISE = 2'd3
  } sig_type_t;
  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;
endpackage

// File: rtl/sample_output_reg_if.sv
// sample_output_reg_if: generator-side capture signals and DAC-side valid/ready stream.
interface sample_output_reg_if import dds_pkg::*; #(
  parameter int DATA_W = SAMPLE_W
) ();
  logic              SIGN_START_CALC;
  logic              SIGN_STOP_CALC;
  logic [DATA_W-1:0] DATA_IN;
  logic              OUT_REG_READY;
  logic [DATA_W-1:0] DAC_DATA;
  logic              DAC_VALID;
  logic              DAC_READY;
  logic              OVERFLOW;
  logic              PROTO_ERR;
  modport master (
    output SIGN_START_CALC, SIGN_STOP_CALC, DATA_IN, DAC_READY,
    input  OUT_REG_READY, DAC_DATA, DAC_VALID, OVERFLOW, PROTO_ERR
  );
  modport slave (
    input  SIGN_START_CALC, SIGN_STOP_CALC, DATA_IN, DAC_READY,
    output OUT_REG_READY, DAC_DATA, DAC_VALID, OVERFLOW, PROTO_ERR
  );
endinterface

// File: rtl/sample_output_reg_fifo.sv
// sample_fifo: sync FIFO whose head is copied into a registered output stage one cycle after it lands.
module sample_fifo import dds_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] IDLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              valid_o,
  output logic              full_o,
  output logic [AW:0]       count_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic vld_q, load;
  logic [DATA_W-1:0] dout_q;
  // cnt_q includes the word held in the output stage, so memory holds cnt_q - vld_q words
  assign load = (cnt_q != {{AW{1'b0}}, vld_q}) && (!vld_q || pop_i);
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      dout_q <= IDLE_VAL;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(load);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      vld_q <= load || (vld_q && !pop_i);
      dout_q <= load ? mem_q[rd_q] : pop_i ? IDLE_VAL : dout_q;
    end
  assign dout_o = dout_q;
  assign valid_o = vld_q;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
endmodule

// File: rtl/sample_output_reg.sv
// sample_output_reg: captures generator frames into a FIFO and streams them to the DAC.
// Define OUT_REG_STATS_EN to add FRAME_SAMPLES (accepted samples of the last completed frame).
module sample_output_reg import dds_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] IDLE_CODE = DEF_IDLE_CODE
) (
  input logic CLK,
  input logic RESET,
  sample_output_reg_if.slave bus
`ifdef OUT_REG_STATS_EN
  , output logic [31:0] FRAME_SAMPLES
`endif
);
  state_t state_q, state_d;
  logic ready_q, ovf_q, perr_q;
  logic idle_start, capture, pop, push, fifo_full;
  logic [ADDR_W:0] fifo_count;
  assign idle_start = (state_q == IDLE) && bus.SIGN_START_CALC;
  assign capture = idle_start || (state_q == CAPTURE);
  assign pop = bus.DAC_VALID && bus.DAC_READY;
  // a pop on the same edge frees a slot, so a full FIFO still accepts
  assign push = capture && (!fifo_full || pop);
  always_comb
    state_d = (state_q == IDLE) ? (bus.SIGN_START_CALC ? (bus.SIGN_STOP_CALC ? DRAIN : CAPTURE) : IDLE)
            : (state_q == CAPTURE) ? (bus.SIGN_STOP_CALC ? DRAIN : CAPTURE)
            : ((fifo_count == '0) ? IDLE : DRAIN);
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d == IDLE;
      ovf_q <= (ovf_q && !idle_start) || (capture && !push);
      perr_q <= (perr_q && !idle_start) || (bus.SIGN_START_CALC && state_q != IDLE);
    end
  sample_fifo #(
    .DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .AW(ADDR_W), .IDLE_VAL(IDLE_CODE)
  ) u_fifo (
    .clk(CLK), .rst_n(RESET), .push_i(push), .pop_i(pop), .din_i(bus.DATA_IN),
    .dout_o(bus.DAC_DATA), .valid_o(bus.DAC_VALID), .full_o(fifo_full), .count_o(fifo_count)
  );
  assign bus.OUT_REG_READY = ready_q;
  assign bus.OVERFLOW = ovf_q;
  assign bus.PROTO_ERR = perr_q;
`ifdef OUT_REG_STATS_EN
  logic [31:0] n_q, n_d, frame_q;
  assign n_d = (idle_start ? 32'd0 : n_q) + 32'(push);
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      n_q <= '0;
      frame_q <= '0;
    end else begin
      n_q <= n_d;
      frame_q <= (capture && bus.SIGN_STOP_CALC) ? n_d : frame_q;
    end
  assign FRAME_SAMPLES = frame_q;
`endif
endmodule

// File: tb/tb_sample_output_reg.sv
// tb_sample_output_reg: directed and random frames against a queue-based reference with a DAC-side scoreboard.
module tb_sample_output_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_fail = 0, n_out = 0, e = 0;
  bit rnd_rdy = 1'b0;
  logic rdy_val = 1'b1;
  localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2;
  typedef struct { logic [11:0] d; int s; } ent_t;
  ent_t mq[$];
  logic [11:0] exp_q[$];
  int m_state = M_IDLE, m_cnt = 0, m_frame = 0;
  bit m_ready = 1'b1, m_ovf = 1'b0, m_perr = 1'b0;
  sample_output_reg_if #(.DATA_W(12)) bus ();
`ifdef OUT_REG_STATS_EN
  logic [31:0] frame_samples;
`endif
  sample_output_reg dut (
    .CLK(clk), .RESET(rst_n), .bus(bus)
`ifdef OUT_REG_STATS_EN
    , .FRAME_SAMPLES(frame_samples)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Reference: queue of stored samples stamped with their capture edge; a sample is shown
  // on the DAC from the second edge after capture, or right after its predecessor leaves.
  always @(posedge clk or negedge rst_n) begin
    int sz0;
    bit vis, pop, cap;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_state = M_IDLE;
      m_ready = 1'b1;
      m_ovf = 1'b0;
      m_perr = 1'b0;
      m_cnt = 0;
      m_frame = 0;
    end else begin
      e++;
      sz0 = mq.size();
      vis = sz0 > 0 && mq[0].s <= e - 2;
      pop = vis && bus.DAC_READY === 1'b1;
      if (pop) void'(mq.pop_front());
      cap = (m_state == M_IDLE && bus.SIGN_START_CALC) || m_state == M_CAP;
      if (m_state == M_IDLE && bus.SIGN_START_CALC) begin
        m_ovf = 1'b0;
        m_perr = 1'b0;
        m_cnt = 0;
      end else if (bus.SIGN_START_CALC) m_perr = 1'b1;
      if (cap) begin
        if (mq.size() < 16) begin
          mq.push_back('{bus.DATA_IN, e});
          exp_q.push_back(bus.DATA_IN);
          m_cnt++;
        end else m_ovf = 1'b1;
      end
      if (cap && bus.SIGN_STOP_CALC) m_frame = m_cnt;
      if (m_state == M_IDLE && bus.SIGN_START_CALC) m_state = bus.SIGN_STOP_CALC ? M_DRAIN : M_CAP;
      else if (m_state == M_CAP && bus.SIGN_STOP_CALC) m_state = M_DRAIN;
      else if (m_state == M_DRAIN && sz0 == 0) m_state = M_IDLE;
      m_ready = m_state == M_IDLE;
    end
  end
  always @(negedge clk) begin
    bit v;
    v = mq.size() > 0 && mq[0].s <= e - 1;
    chk("dac_valid", 32'(bus.DAC_VALID), 32'(v));
    chk("dac_data", 32'(bus.DAC_DATA), v ? 32'(mq[0].d) : 32'd0);
    chk("out_reg_ready", 32'(bus.OUT_REG_READY), 32'(m_ready));
    chk("overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
    chk("proto_err", 32'(bus.PROTO_ERR), 32'(m_perr));
`ifdef OUT_REG_STATS_EN
    chk("frame_samples", frame_samples, 32'(m_frame));
`endif
  end
  always @(negedge clk)
    if (rst_n && bus.DAC_VALID === 1'b1 && bus.DAC_READY === 1'b1) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra: got 0x%0h, expected no sample (t=%0t)", bus.DAC_DATA, $time);
      end else chk("sb_data", 32'(bus.DAC_DATA), 32'(exp_q.pop_front()));
    end
  task automatic tick();
    @(posedge clk);
    #1;
    bus.DAC_READY = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
  endtask
  task automatic send_frame(input int n, input int dup, input logic [11:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      bus.SIGN_START_CALC = (i == 0) || (i == dup);
      bus.SIGN_STOP_CALC = i == n - 1;
      bus.DATA_IN = rnd ? 12'($urandom) : base + 12'(i);
      tick();
    end
    bus.SIGN_START_CALC = 1'b0;
    bus.SIGN_STOP_CALC = 1'b0;
    bus.DATA_IN = 'z;
  endtask
  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(bus.OUT_REG_READY === 1'b1 && mq.size() == 0) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_idle_in_budget", 32'(k < budget), 32'd1);
  endtask
  initial begin
    int n0, len, dup;
    bit skip;
    bus.SIGN_START_CALC = 1'b0;
    bus.SIGN_STOP_CALC = 1'b0;
    bus.DATA_IN = 'z;
    bus.DAC_READY = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("t1_ready", 32'(bus.OUT_REG_READY), 32'd1);
    chk("t1_valid", 32'(bus.DAC_VALID), 32'd0);
    chk("t1_data", 32'(bus.DAC_DATA), 32'd0);
    n0 = n_out;
    send_frame(5, -1, 12'd1, 1'b0);
    chk("t2_ready_low", 32'(bus.OUT_REG_READY), 32'd0);
    wait_idle(100);
    chk("t2_count", 32'(n_out - n0), 32'd5);
    n0 = n_out;
    send_frame(1, -1, 12'hABC, 1'b0);
    wait_idle(100);
    chk("t3_count", 32'(n_out - n0), 32'd1);
    chk("t3_ready", 32'(bus.OUT_REG_READY), 32'd1);
    rdy_val = 1'b0;
    tick();
    send_frame(20, -1, 12'd100, 1'b0);
    chk("t4_overflow", 32'(bus.OVERFLOW), 32'd1);
    n0 = n_out;
    rdy_val = 1'b1;
    wait_idle(100);
    chk("t4_count", 32'(n_out - n0), 32'd16);
`ifdef OUT_REG_STATS_EN
    chk("t4_frame_samples", frame_samples, 32'd16);
`endif
    n0 = n_out;
    send_frame(6, 2, 12'd200, 1'b0);
    chk("t5_proto_err", 32'(bus.PROTO_ERR), 32'd1);
    wait_idle(100);
    chk("t5_count", 32'(n_out - n0), 32'd6);
    rdy_val = 1'b0;
    tick();
    bus.SIGN_START_CALC = 1'b1;
    bus.DATA_IN = 12'd1;
    tick();
    bus.SIGN_START_CALC = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      bus.DATA_IN = 12'(i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.DAC_VALID), 32'd0);
    chk("t6_ready", 32'(bus.OUT_REG_READY), 32'd1);
    chk("t6_data", 32'(bus.DAC_DATA), 32'd0);
    chk("t6_fifo_count", 32'(dut.u_fifo.cnt_q), 32'd0);
    bus.DATA_IN = 'z;
    tick();
    tick();
    rst_n = 1'b1;
    rdy_val = 1'b1;
    tick();
    n0 = n_out;
    send_frame(4, -1, 12'd300, 1'b0);
    wait_idle(100);
    chk("t6_count", 32'(n_out - n0), 32'd4);
    rnd_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 24);
      dup = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      skip = $urandom_range(0, 3) == 0;
      send_frame(len, dup, 12'd0, 1'b1);
      if (skip) repeat ($urandom_range(0, 3)) tick();
      else wait_idle(300);
    end
    rnd_rdy = 1'b0;
    rdy_val = 1'b1;
    wait_idle(300);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
